// File: rtl/br_local_adapter.sv
// BrLite local-port adapter: NI <-> router handshakes, with a sequence-stamping TX FIFO
// and an RX FIFO, one of each.
package br_local_adapter_pkg;
  typedef struct packed {
    logic [3:0]  ksvc;
    logic [15:0] seq_source;
    logic [15:0] payload;
  } br_payload_t;
endpackage

module br_local_adapter
  import br_local_adapter_pkg::*;
#(
  parameter logic [15:0] ADDRESS    = 16'b0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ni_req_i,
  output logic        ni_ack_o,
  input  br_payload_t ni_data_i,
  output logic        ni_rx_o,
  output br_payload_t ni_data_o,
  input  logic        ni_rx_ack_i,
  output logic        local_busy_o,
  output logic        rt_req_o,
  input  logic        rt_ack_i,
  output br_payload_t rt_data_o,
  input  logic        rt_req_i,
  output logic        rt_ack_o,
  input  br_payload_t rt_data_i
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_GAP} tx_state_t;

  tx_state_t   r_state, w_state_nxt;
  logic        r_ni_ack, r_rt_ack, r_rt_req, r_busy;
  logic [7:0]  r_seq;
  br_payload_t r_rt_data;

  br_payload_t r_tx_mem [FIFO_DEPTH];
  logic [AW-1:0] r_tx_wr, r_tx_rd;
  logic [CW-1:0] r_tx_cnt, w_tx_cnt_nxt;
  logic          w_tx_push, w_tx_pop;
  br_payload_t   w_tx_entry;

  br_payload_t r_rx_mem [FIFO_DEPTH];
  logic [AW-1:0] r_rx_wr, r_rx_rd;
  logic [CW-1:0] r_rx_cnt;
  logic          w_rx_push, w_rx_pop;

  logic w_unused_seq;
  assign w_unused_seq = ^ni_data_i.seq_source;

  // A pop on the same edge frees a slot, so a full FIFO can still accept.
  assign w_tx_push = ni_req_i && !r_ni_ack && ((r_tx_cnt != DEPTH_C) || w_tx_pop);
  assign w_tx_cnt_nxt = r_tx_cnt + CW'(w_tx_push) - CW'(w_tx_pop);
  assign w_tx_entry = '{ksvc:       ni_data_i.ksvc,
                        seq_source: {r_seq, ADDRESS[11:8], ADDRESS[3:0]},
                        payload:    ni_data_i.payload};

  assign w_rx_pop  = ni_rx_ack_i && (r_rx_cnt != '0);
  assign w_rx_push = rt_req_i && !r_rt_ack && ((r_rx_cnt != DEPTH_C) || w_rx_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tx_pop    = 1'b0;
    unique case (r_state)
      ST_IDLE: if (r_tx_cnt != '0) w_state_nxt = ST_REQ;
      ST_REQ: begin
        if (rt_ack_i) begin
          w_state_nxt = ST_GAP;
          w_tx_pop    = 1'b1;
        end
      end
      ST_GAP:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ni_ack  <= 1'b0;
      r_seq     <= '0;
      r_tx_wr   <= '0;
      r_tx_rd   <= '0;
      r_tx_cnt  <= '0;
      r_rt_req  <= 1'b0;
      r_rt_data <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_ni_ack <= w_tx_push;
      if (w_tx_push) begin
        r_tx_wr <= r_tx_wr + 1'b1;
        r_seq   <= r_seq + 1'b1;
      end
      if (w_tx_pop) r_tx_rd <= r_tx_rd + 1'b1;
      r_tx_cnt <= w_tx_cnt_nxt;
      r_rt_req <= (w_state_nxt == ST_REQ);
      // Head is latched on REQ entry so rt_data_o stays stable through the handshake.
      if ((r_state == ST_IDLE) && (w_state_nxt == ST_REQ)) r_rt_data <= r_tx_mem[r_tx_rd];
      r_busy <= (w_tx_cnt_nxt != '0) || (w_state_nxt != ST_IDLE);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_tx_push) r_tx_mem[r_tx_wr] <= w_tx_entry;
    if (w_rx_push) r_rx_mem[r_rx_wr] <= rt_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rt_ack <= 1'b0;
      r_rx_wr  <= '0;
      r_rx_rd  <= '0;
      r_rx_cnt <= '0;
    end else begin
      r_rt_ack <= w_rx_push;
      if (w_rx_push) r_rx_wr <= r_rx_wr + 1'b1;
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + 1'b1;
      r_rx_cnt <= r_rx_cnt + CW'(w_rx_push) - CW'(w_rx_pop);
    end
  end

  assign ni_ack_o     = r_ni_ack;
  assign rt_ack_o     = r_rt_ack;
  assign rt_req_o     = r_rt_req;
  assign rt_data_o    = r_rt_data;
  assign local_busy_o = r_busy;
  assign ni_rx_o      = (r_rx_cnt != '0);
  assign ni_data_o    = (r_rx_cnt != '0) ? r_rx_mem[r_rx_rd] : '0;

endmodule

// File: tb/tb_br_local_adapter.sv
// Directed self-checking bench for br_local_adapter (ADDRESS=16'h0302, FIFO_DEPTH=4).
module tb_br_local_adapter;
  import br_local_adapter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i, ni_req_i, ni_rx_ack_i, rt_ack_i, rt_req_i;
  logic        ni_ack_o, ni_rx_o, local_busy_o, rt_req_o, rt_ack_o;
  br_payload_t ni_data_i, ni_data_o, rt_data_o, rt_data_i;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  br_local_adapter #(.ADDRESS(16'h0302), .FIFO_DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .ni_req_i(ni_req_i), .ni_ack_o(ni_ack_o), .ni_data_i(ni_data_i),
    .ni_rx_o(ni_rx_o), .ni_data_o(ni_data_o), .ni_rx_ack_i(ni_rx_ack_i),
    .local_busy_o(local_busy_o),
    .rt_req_o(rt_req_o), .rt_ack_i(rt_ack_i), .rt_data_o(rt_data_o),
    .rt_req_i(rt_req_i), .rt_ack_o(rt_ack_o), .rt_data_i(rt_data_i)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected outgoing word for ADDRESS 16'h0302: low seq_source byte is 8'h32.
  function automatic br_payload_t tx_msg(input logic [3:0] k, input logic [7:0] s, input logic [15:0] p);
    return {k, s, 8'h32, p};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1; ni_req_i = 1'b0; ni_rx_ack_i = 1'b0; rt_ack_i = 1'b0; rt_req_i = 1'b0;
    ni_data_i = '0; rt_data_i = '0;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic ni_send(input br_payload_t d, input int max_cyc, output bit ok);
    ni_data_i = d;
    ni_req_i  = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (ni_ack_o) begin ok = 1'b1; break; end
    end
    if (ok) ni_req_i = 1'b0;
  endtask

  task automatic rt_take(output br_payload_t got, output bit ok);
    ok = 1'b0;
    got = '0;
    for (int i = 0; i < 12; i++) begin
      if (rt_req_o) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) begin
      got = rt_data_o;
      rt_ack_i = 1'b1;
      @(negedge clk);
      rt_ack_i = 1'b0;
    end
  endtask

  task automatic rt_deliver(input br_payload_t d, input int max_cyc, output bit ok);
    rt_data_i = d;
    rt_req_i  = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (rt_ack_o) begin ok = 1'b1; break; end
    end
    if (ok) rt_req_i = 1'b0;
  endtask

  task automatic ni_pop();
    ni_rx_ack_i = 1'b1;
    @(negedge clk);
    ni_rx_ack_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    bit ok, ok2, allok;
    br_payload_t got;
    br_payload_t m [5];

    // Reset state
    do_reset();
    check("rst_ni_ack", ni_ack_o, 1'b0);
    check("rst_rt_ack", rt_ack_o, 1'b0);
    check("rst_rt_req", rt_req_o, 1'b0);
    check("rst_ni_rx", ni_rx_o, 1'b0);
    check("rst_busy", local_busy_o, 1'b0);
    check("rst_rt_data", rt_data_o, 36'h0);
    check("rst_ni_data", ni_data_o, 36'h0);

    // Single send; req held one extra edge must not duplicate
    ni_data_i = {4'h5, 16'hFFFF, 16'hBEEF};
    ni_req_i  = 1'b1;
    @(negedge clk);
    check("t1_ack", ni_ack_o, 1'b1);
    check("t1_req_early", rt_req_o, 1'b0);
    check("t1_busy", local_busy_o, 1'b1);
    @(negedge clk);
    check("t1_ack_pulse", ni_ack_o, 1'b0);
    check("t1_rt_req", rt_req_o, 1'b1);
    check("t1_rt_data", rt_data_o, tx_msg(4'h5, 8'h00, 16'hBEEF));
    ni_req_i = 1'b0;
    rt_ack_i = 1'b1;
    @(negedge clk);
    rt_ack_i = 1'b0;
    check("t1_gap", rt_req_o, 1'b0);
    check("t1_gap_busy", local_busy_o, 1'b1);
    @(negedge clk);
    check("t1_no_dup", rt_req_o, 1'b0);
    check("t1_idle_busy", local_busy_o, 1'b0);
    repeat (2) @(negedge clk);
    check("t1_no_dup2", rt_req_o, 1'b0);

    // TX FIFO full stall and release
    do_reset();
    for (int i = 0; i < 4; i++) begin
      ni_send({4'h1, 16'h0000, 16'h1000 + 16'(i)}, 6, ok);
      check($sformatf("t2_ack%0d", i), ok, 1'b1);
    end
    ni_send({4'h1, 16'h0000, 16'h1004}, 6, ok);
    check("t2_stall", ok, 1'b0);
    check("t2_head_req", rt_req_o, 1'b1);
    check("t2_head", rt_data_o, tx_msg(4'h1, 8'h00, 16'h1000));
    rt_ack_i = 1'b1;
    @(negedge clk);
    rt_ack_i = 1'b0;
    ok = ni_ack_o;
    if (!ok) begin @(negedge clk); ok = ni_ack_o; end
    ni_req_i = 1'b0;
    check("t2_fifth_ack", ok, 1'b1);
    for (int i = 1; i < 5; i++) begin
      rt_take(got, ok);
      check($sformatf("t2_take%0d", i), ok, 1'b1);
      check($sformatf("t2_data%0d", i), got, tx_msg(4'h1, 8'(i), 16'h1000 + 16'(i)));
    end

    // RX ordering
    do_reset();
    m[0] = {4'h7, 16'h1111, 16'hA000};
    m[1] = {4'h8, 16'h2222, 16'hA001};
    m[2] = {4'h9, 16'h3333, 16'hA002};
    m[3] = {4'hA, 16'h4444, 16'hA003};
    m[4] = {4'hB, 16'h5555, 16'hA004};
    for (int i = 0; i < 3; i++) begin
      rt_deliver(m[i], 6, ok);
      check($sformatf("t3_rtack%0d", i), ok, 1'b1);
    end
    check("t3_rx", ni_rx_o, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t3_data%0d", i), ni_data_o, m[i]);
      ni_pop();
    end
    check("t3_empty", ni_rx_o, 1'b0);
    check("t3_empty_data", ni_data_o, 36'h0);

    // RX full with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rt_deliver(m[i], 6, ok);
      check($sformatf("t4_fill%0d", i), ok, 1'b1);
    end
    rt_deliver(m[4], 4, ok);
    check("t4_stall", ok, 1'b0);
    ni_rx_ack_i = 1'b1;
    @(negedge clk);
    ni_rx_ack_i = 1'b0;
    rt_req_i = 1'b0;
    check("t4_simul_ack", rt_ack_o, 1'b1);
    for (int i = 1; i < 5; i++) begin
      check($sformatf("t4_data%0d", i), ni_data_o, m[i]);
      check($sformatf("t4_rx%0d", i), ni_rx_o, 1'b1);
      ni_pop();
    end
    check("t4_empty", ni_rx_o, 1'b0);
    ni_pop();
    rt_deliver(m[2], 6, ok);
    check("t4_after_empty_pop", ni_data_o, m[2]);
    ni_pop();
    check("t4_empty2", ni_rx_o, 1'b0);

    // Sequence counter wrap
    do_reset();
    allok = 1'b1;
    for (int i = 0; i < 257; i++) begin
      ni_send({4'hA, 16'hA5A5, 16'(i)}, 8, ok);
      rt_take(got, ok2);
      allok = allok & ok & ok2;
      if (i == 255) check("t5_seq255", got.seq_source[15:8], 8'hFF);
      if (i == 256) check("t5_seq_wrap", got, tx_msg(4'hA, 8'h00, 16'h0100));
    end
    check("t5_handshakes", allok, 1'b1);

    // Reset mid-handshake
    do_reset();
    ni_send({4'h2, 16'h0, 16'hC000}, 6, ok);
    ni_send({4'h2, 16'h0, 16'hC001}, 6, ok2);
    check("t6_tx_sends", ok & ok2, 1'b1);
    rt_deliver(m[0], 6, ok);
    rt_deliver(m[1], 6, ok2);
    check("t6_rx_delivers", ok & ok2, 1'b1);
    check("t6_req_before", rt_req_o, 1'b1);
    check("t6_rx_before", ni_rx_o, 1'b1);
    rst_i = 1'b1; ni_req_i = 1'b1; rt_req_i = 1'b1;
    @(negedge clk);
    check("t6_ni_ack", ni_ack_o, 1'b0);
    check("t6_rt_ack", rt_ack_o, 1'b0);
    check("t6_rt_req", rt_req_o, 1'b0);
    check("t6_ni_rx", ni_rx_o, 1'b0);
    check("t6_busy", local_busy_o, 1'b0);
    check("t6_rt_data", rt_data_o, 36'h0);
    check("t6_ni_data", ni_data_o, 36'h0);
    rst_i = 1'b0; ni_req_i = 1'b0; rt_req_i = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_post_req", rt_req_o, 1'b0);
    check("t6_post_rx", ni_rx_o, 1'b0);
    check("t6_post_busy", local_busy_o, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/br_local_adapter.md
BR_LOCAL_ADAPTER -- requirements
Module: br_local_adapter

Interface
REQ-001 Parameter ADDRESS, 16'b0, PE address; bits [11:8] and [3:0] stamp outgoing seq_source.
REQ-002 Parameter FIFO_DEPTH, 4, entries per direction; power of two, at least 2.
REQ-003 Port clk_i, in, 1, single clock; all logic samples on its rising edge.
REQ-004 Port rst_i, in, 1, reset; synchronous, active-high.
REQ-005 Port ni_req_i, in, 1, NI send request; held high until ni_ack_o is seen.
REQ-006 Port ni_ack_o, out, 1, one-cycle pulse accepting ni_data_i.
REQ-007 Port ni_data_i, in, br_payload_t, NI outgoing ksvc and payload; seq_source ignored.
REQ-008 Port ni_rx_o, out, 1, received message available to NI.
REQ-009 Port ni_data_o, out, br_payload_t, head of RX FIFO.
REQ-010 Port ni_rx_ack_i, in, 1, one-cycle pulse from NI consuming the RX head.
REQ-011 Port local_busy_o, out, 1, TX path non-empty or handshake in flight.
REQ-012 Port rt_req_o, out, 1, request to BrLite router local port.
REQ-013 Port rt_ack_i, in, 1, router accept of rt_data_o.
REQ-014 Port rt_data_o, out, br_payload_t, outgoing message to router.
REQ-015 Port rt_req_i, in, 1, router delivering a message; held until rt_ack_o.
REQ-016 Port rt_ack_o, out, 1, one-cycle pulse accepting rt_data_i.
REQ-017 Port rt_data_i, in, br_payload_t, incoming message from router.

Function
REQ-018 TX accept: the block SHALL register ni_ack_o high for exactly one cycle when ni_req_i is high, ni_ack_o is low and the TX FIFO is not full, and SHALL push in the same edge.
REQ-019 The pushed entry SHALL carry ksvc and payload from ni_data_i, with seq_source = {seq_cnt[7:0], ADDRESS[11:8], ADDRESS[3:0]}.
REQ-020 seq_cnt SHALL increment on every TX push and wrap 255 -> 0.
REQ-021 If the TX FIFO is full, ni_ack_o SHALL stay low and ni_req_i SHALL wait without loss.
REQ-022 The cycle after an ack, ni_req_i SHALL be ignored regardless of level, so one NI request yields at most one push.
REQ-023 The TX FSM SHALL have states IDLE, REQ and GAP.
REQ-024 IDLE -> REQ when the TX FIFO is non-empty.
REQ-025 In REQ, rt_req_o = 1 and rt_data_o = TX head, held stable.
REQ-026 REQ -> GAP on rt_ack_i; the FIFO pops on that edge.
REQ-027 GAP lasts one cycle with rt_req_o = 0, then returns to IDLE.
REQ-028 rt_req_o SHALL be registered and first assert one cycle after the entry is written.
REQ-029 RX accept: the block SHALL pulse rt_ack_o for one cycle and push rt_data_i unmodified when rt_req_i is high, rt_ack_o is low and the RX FIFO is not full; a full FIFO stalls the router.
REQ-030 ni_rx_o SHALL equal "RX FIFO non-empty"; ni_data_o SHALL be the RX head and is valid while ni_rx_o is high.
REQ-031 ni_rx_ack_i SHALL pop one entry; a pop while the RX FIFO is empty SHALL be ignored with no pointer change.
REQ-032 Simultaneous push and pop on either FIFO SHALL both take effect with unchanged occupancy, including when full (pop frees the slot the same edge) and when empty (no pop).
REQ-033 Pointers SHALL wrap modulo FIFO_DEPTH, with occupancy counts of width clog2(FIFO_DEPTH)+1.
REQ-034 local_busy_o SHALL be registered high while the TX FIFO is non-empty or the TX FSM is not IDLE.

Reset
REQ-035 While rst_i is high at a clock edge, the block SHALL clear to IDLE: both FIFOs empty, seq_cnt = 0, and ni_ack_o, rt_ack_o, rt_req_o, ni_rx_o, local_busy_o all 0.
REQ-036 rt_data_o and ni_data_o SHALL reset to all zeros.
REQ-037 Reset mid-handshake SHALL discard all queued and in-flight messages; no ack is emitted on the reset cycle.

Verification
REQ-038 ADDRESS=16'h0302; NI sends ksvc=4'h5, payload=16'hBEEF -> ni_ack_o 1 cycle; rt_req_o high 1 cycle later; rt_data_o.seq_source = 16'h0032; after rt_ack_i, rt_req_o 0 for 1 cycle.
REQ-039 Hold rt_ack_i low, issue 5 NI sends -> 4 acks; 5th req stalls; one rt_ack_i -> 5th acked within 2 cycles; seq_source[15:8] values 0,1,2,3,4.
REQ-040 Router delivers 3 messages while NI never acks -> ni_rx_o high; ni_data_o = first message; 3 ni_rx_ack_i pulses -> messages in order, then ni_rx_o = 0.
REQ-041 RX FIFO full with simultaneous rt_req_i and ni_rx_ack_i -> rt_ack_o pulses that cycle; occupancy stays 4.
REQ-042 Send 256 messages -> the 257th carries seq_source[15:8] = 8'h00.
REQ-043 Assert rst_i while rt_req_o is high with 2 TX and 2 RX entries queued -> next cycle all outputs 0 and local_busy_o 0.
